// File: rtl/dmem_arbiter.sv
// Two-port (core/debug) arbiter and access sequencer for the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with a HOLD_MAX starvation guard.
module dmem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = 1,
   parameter int HOLD_MAX = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                c_req_valid,
   output logic                c_req_ready,
   input  logic                c_req_we,
   input  logic [ADDR_W-1:0]   c_req_addr,
   input  logic [DATA_W-1:0]   c_req_wdata,
   input  logic [DATA_W/8-1:0] c_req_be,
   output logic                c_rsp_valid,
   output logic [DATA_W-1:0]   c_rsp_rdata,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic                d_req_we,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_be,
   output logic                d_rsp_valid,
   output logic [DATA_W-1:0]   d_rsp_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy,
   output logic                grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_next;
   logic [1:0]        lat_cnt;
   logic [DATA_W-1:0] rsp_data;
   logic              core_first;
   logic              c_win;
   logic              accept;

`ifdef DMEM_ARB_RR_EN
   // Pointer holds the last granted id; the other requester wins a tie.
   logic rr_ptr;
   assign core_first = rr_ptr;
`else
   logic [7:0] hold_cnt;
   assign core_first = (hold_cnt != 8'(HOLD_MAX));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Ready only in IDLE and never while reset is high; responses go to the latched owner.
   always_comb begin
      state_next  = state;
      c_win       = c_req_valid && (core_first || !d_req_valid);
      c_req_ready = 1'b0;
      d_req_ready = 1'b0;
      c_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
      c_rsp_rdata = '0;
      d_rsp_rdata = '0;
      case (state)
         IDLE: begin
            c_req_ready = c_win && !reset;
            d_req_ready = d_req_valid && !c_win && !reset;
            if (c_req_ready || d_req_ready) begin
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = mem_we ? RESP : WAIT;
         WAIT: begin
            if (lat_cnt == 2'd0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            c_rsp_valid = !grant_id;
            d_rsp_valid = grant_id;
            c_rsp_rdata = grant_id ? '0 : rsp_data;
            d_rsp_rdata = grant_id ? rsp_data : '0;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept = c_req_ready || d_req_ready;
   assign busy   = (state != IDLE);

   // mem_we is only high in ISSUE, so it doubles as the write/read selector there.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         grant_id  <= 1'b0;
         rsp_data  <= '0;
         lat_cnt   <= '0;
`ifdef DMEM_ARB_RR_EN
         rr_ptr    <= 1'b1;
`else
         hold_cnt  <= '0;
`endif
      end else begin
         mem_en <= accept;
         mem_we <= accept && (d_req_ready ? d_req_we : c_req_we);
         if (accept) begin
            mem_addr  <= d_req_ready ? d_req_addr  : c_req_addr;
            mem_wdata <= d_req_ready ? d_req_wdata : c_req_wdata;
            mem_be    <= d_req_ready ? d_req_be    : c_req_be;
            grant_id  <= d_req_ready;
            rsp_data  <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_ptr    <= d_req_ready;
`else
            if (d_req_ready || !d_req_valid) begin
               hold_cnt <= '0;
            end else if (hold_cnt != 8'hFF) begin
               hold_cnt <= hold_cnt + 8'd1;
            end
`endif
         end
         if (state == ISSUE) begin
            lat_cnt <= 2'(MEM_LAT - 1);
         end else if (state == WAIT && lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
         end
         if (state == WAIT && lat_cnt == 2'd0) begin
            rsp_data <= mem_rdata;
         end
      end
   end

endmodule
